mgmt_stream_arbiter: RTL and testbench
======================================

MGMT_STREAM_ARBITER -- requirements
Module: mgmt_stream_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, meaning tdata width of every slave port and of the master port.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, meaning tuser width of every port.
REQ-003 SHALL have parameter NUM_PORTS, default 4, legal range 2..8, meaning number of slave stream ports.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, meaning width of each statistics counter.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port axi_aclk, input, 1 bit: the single clock.
REQ-007 SHALL have port axi_aresetn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports s_axis_tdata (input, NUM_PORTS*C_AXIS_DATA_WIDTH), s_axis_tstrb (input, NUM_PORTS*C_AXIS_DATA_WIDTH/8) and s_axis_tuser (input, NUM_PORTS*C_AXIS_TUSER_WIDTH), packed with port i at slice i.
REQ-009 SHALL have ports s_axis_tvalid (input, NUM_PORTS), s_axis_tlast (input, NUM_PORTS) and s_axis_tready (output, NUM_PORTS), one bit per port.
REQ-010 SHALL have ports m_axis_tdata (output, C_AXIS_DATA_WIDTH), m_axis_tstrb (output, C_AXIS_DATA_WIDTH/8), m_axis_tuser (output, C_AXIS_TUSER_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1).
REQ-011 SHALL have port ctrl_reg, input, 32 bits: [NUM_PORTS-1:0] port enable mask; [16] drop_disabled; [31] clear_counters, level-sensitive.
REQ-012 SHALL have ports pkt_count (output, NUM_PORTS*CNT_WIDTH, forwarded packets) and drop_count (output, NUM_PORTS*CNT_WIDTH, dropped packets), packed per port.
REQ-013 SHALL have ports grant_port (output, 3 bits, index of the current or last granted port) and busy (output, 1 bit, high in state SEND).

Function
REQ-014 SHALL use an FSM with exactly two states, IDLE and SEND.
REQ-015 In IDLE, a port SHALL be eligible when its tvalid=1, its enable bit=1, and it has no drop in progress.
REQ-016 In IDLE with one or more eligible ports, the FSM SHALL select by round-robin the first eligible port after the last granted port, wrapping from NUM_PORTS-1 to 0, register that port into grant_port, and enter SEND on the next cycle.
REQ-017 In SEND, m_axis_* SHALL carry the granted port's tdata/tstrb/tuser/tvalid/tlast unmodified and combinationally, with s_axis_tready[grant]=m_axis_tready; there SHALL be no data latency.
REQ-018 In IDLE, m_axis_tvalid SHALL be 0 and s_axis_tready SHALL be 0 for every non-dropping port.
REQ-019 A beat with tvalid, tready and tlast all high in SEND SHALL increment pkt_count[grant] and return the FSM to IDLE, giving one idle cycle between packets.
REQ-020 Clearing a port's enable bit while that port is granted SHALL NOT truncate the packet; the port SHALL finish through tlast.
REQ-021 When drop_disabled=1, a disabled port that is not granted and presents tvalid at a packet boundary SHALL start a drop: tready=1 until its tlast beat completes, then drop_count[i] increments by 1.
REQ-022 A drop SHALL run concurrently with SEND on a different port.
REQ-023 A port SHALL track a packet boundary through a per-port in_packet flag, so that drops begin only on a first beat.
REQ-024 When drop_disabled=0, a disabled port SHALL be held off with tready=0.
REQ-025 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-026 When clear_counters=1, all counters SHALL read 0 on the next cycle; clear SHALL take priority over a simultaneous increment.
REQ-027 A tvalid=1 beat with m_axis_tready=0 SHALL be held with no loss or duplication, and tdata SHALL be stable until accepted.

Reset
REQ-028 While axi_aresetn=0, the block SHALL hold state=IDLE, grant_port=NUM_PORTS-1 (so port 0 wins first), busy=0, m_axis_tvalid=0, s_axis_tready=0, all counters=0, and all in_packet and drop flags=0, asynchronously.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no counter update; after release, arbitration SHALL restart from port 0.

Verification
REQ-030 All ports enabled, ports 0-3 each send 3 single-beat packets simultaneously -> output order 0,1,2,3,0,1,2,3,..., each pkt_count=3.
REQ-031 Port 1 sends a 5-beat packet while m_axis_tready toggles 1,0,1,0 -> exactly 5 beats out, identical data, tlast on beat 5, pkt_count[1]=1.
REQ-032 ctrl_reg=0x0001_000E (port 0 disabled, drop on), port 0 sends a 2-beat packet while port 2 sends a 4-beat packet -> port 0 drained in 2 cycles with drop_count[0]=1; port 2 forwarded intact with pkt_count[2]=1.
REQ-033 Port 3 enable cleared at beat 2 of a 6-beat packet -> all 6 beats forwarded, later port 3 packets held with tready=0 (drop off).
REQ-034 pkt_count[0]=0xFFFF_FFFF, then one more packet -> 0; clear_counters asserted in the same cycle as a tlast -> 0.
REQ-035 axi_aresetn pulsed low at beat 3 of a packet -> m_axis_tvalid=0 immediately, counters 0, next grant goes to port 0.

Source files
------------

// File: rtl/mgmt_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mgmt_stream_arbiter
// Brief    : Round-robin N:1 AXI-Stream packet arbiter with per-port drop and counters.
// Revision : 1.0
// ============================================================================
module mgmt_stream_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                      axi_aclk,
    input  logic                                      axi_aresetn,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    input  logic [31:0]                               ctrl_reg,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]            pkt_count,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]            drop_count,
    output logic [2:0]                                grant_port,
    output logic                                      busy
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             grant_q, grant_d;
    logic [NUM_PORTS-1:0]   in_pkt_q, in_pkt_d;
    logic [NUM_PORTS-1:0]   drop_q, drop_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   pkt_cnt_d  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   drop_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   drop_cnt_d [NUM_PORTS];

    logic [NUM_PORTS-1:0]   port_en;
    logic                   drop_en;
    logic                   clr_cnt;
    logic [NUM_PORTS-1:0]   is_grant;
    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   dropping;
    logic [NUM_PORTS-1:0]   accept;
    logic                   sel_valid;
    logic                   sel_last;
    logic [7:0]             elig_ext;
    logic [3:0]             idx;
    logic [2:0]             sel;
    logic                   found;
    logic                   unused_ctrl;

    assign port_en     = ctrl_reg[NUM_PORTS-1:0];
    assign drop_en     = ctrl_reg[16];
    assign clr_cnt     = ctrl_reg[31];
    assign unused_ctrl = ^{ctrl_reg[30:17], ctrl_reg[15:NUM_PORTS]};
    assign grant_port  = grant_q;
    assign busy        = (state_q == S_SEND);

    // Drops start only on a first beat, on a port that is not the one being forwarded.
    always_comb begin
        is_grant = '0;
        eligible = '0;
        dropping = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            is_grant[i] = busy && (grant_q == 3'(i));
            eligible[i] = s_axis_tvalid[i] & port_en[i] & ~drop_q[i];
            dropping[i] = drop_q[i] |
                          (axi_aresetn & drop_en & ~port_en[i] & s_axis_tvalid[i] &
                           ~in_pkt_q[i] & ~is_grant[i]);
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        s_axis_tready = '0;
        accept        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == 3'(i)) begin
                m_axis_tdata = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                m_axis_tstrb = s_axis_tstrb[i*STRB_W +: STRB_W];
                m_axis_tuser = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
                sel_valid    = s_axis_tvalid[i];
                sel_last     = s_axis_tlast[i];
            end
            s_axis_tready[i] = is_grant[i] ? m_axis_tready : dropping[i];
            accept[i]        = s_axis_tvalid[i] & s_axis_tready[i];
        end
        m_axis_tvalid = busy & sel_valid;
        m_axis_tlast  = busy & sel_last;
    end

    // Round-robin search starting one past the last granted port.
    always_comb begin
        elig_ext                = '0;
        elig_ext[NUM_PORTS-1:0] = eligible;
        idx                     = '0;
        sel                     = grant_q;
        found                   = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = {1'b0, grant_q} + 4'(k);
            if (idx >= 4'(NUM_PORTS)) begin
                idx = idx - 4'(NUM_PORTS);
            end
            if (!found && elig_ext[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        in_pkt_d   = in_pkt_q;
        drop_d     = drop_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == S_IDLE && found) begin
            grant_d = sel;
            state_d = S_SEND;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept[i]) begin
                in_pkt_d[i] = ~s_axis_tlast[i];
            end
            if (dropping[i] && accept[i]) begin
                drop_d[i] = ~s_axis_tlast[i];
                if (s_axis_tlast[i]) begin
                    drop_cnt_d[i] = drop_cnt_q[i] + 1'b1;
                end
            end
            if (is_grant[i] && accept[i] && s_axis_tlast[i]) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
                state_d      = S_IDLE;
            end
        end
        if (clr_cnt) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_d[i]  = '0;
                drop_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= S_IDLE;
            grant_q  <= 3'(NUM_PORTS - 1);
            in_pkt_q <= '0;
            drop_q   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_q[i]  <= '0;
                drop_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            in_pkt_q   <= in_pkt_d;
            drop_q     <= drop_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt_pack
            assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH]  = pkt_cnt_q[i];
            assign drop_count[i*CNT_WIDTH +: CNT_WIDTH] = drop_cnt_q[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mgmt_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgmt_stream_arbiter
// Brief    : Directed self-checking bench for mgmt_stream_arbiter (4 ports, 4-bit counters).
// Revision : 1.0
// ============================================================================
module tb_mgmt_stream_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int CW = 4;
    localparam int SW = DW / 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP*SW-1:0]   s_tstrb;
    logic [NP*UW-1:0]   s_tuser;
    logic [NP-1:0]      s_tvalid;
    logic [NP-1:0]      s_tlast;
    logic [NP-1:0]      s_tready;
    logic [DW-1:0]      m_tdata;
    logic [SW-1:0]      m_tstrb;
    logic [UW-1:0]      m_tuser;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [31:0]        ctrl;
    logic [NP*CW-1:0]   pkt_count;
    logic [NP*CW-1:0]   drop_count;
    logic [2:0]         grant_port;
    logic               busy;

    mgmt_stream_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS          (NP),
        .CNT_WIDTH          (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .ctrl_reg      (ctrl),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
        .grant_port    (grant_port),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [32:0]  srcq [NP][$];
    logic [43:0]  outq [$];
    logic [NP-1:0] acc;
    logic         tr_mode = 1'b0;
    logic         tog     = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkd(input int p, input int n, input int b);
        return 32'hA000_0000 | (32'(p) << 20) | (32'(n) << 8) | 32'(b);
    endfunction

    function automatic logic [CW-1:0] pcnt(input int p);
        return pkt_count[p*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] dcnt(input int p);
        return drop_count[p*CW +: CW];
    endfunction

    task automatic push_pkt(input int p, input int n, input int beats);
        for (int b = 0; b < beats; b++) begin
            srcq[p].push_back({(b == beats - 1), mkd(p, n, b)});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tlast[i]           = srcq[i][0][32];
                s_tdata[i*DW +: DW]  = srcq[i][0][31:0];
                s_tuser[i*UW +: UW]  = srcq[i][0][7:0] ^ 8'h5A;
                s_tstrb[i*SW +: SW]  = srcq[i][0][3:0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        if (tr_mode) begin
            m_tready = ~tog;
            tog      = ~tog;
        end else begin
            m_tready = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            acc = s_tvalid & s_tready;
            if (m_tvalid && m_tready) begin
                outq.push_back({grant_port, m_tlast, m_tuser, m_tdata});
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) void'(srcq[i].pop_front());
            end
        end
    endtask

    task automatic expect_out(input int p, input int n, input int beats, input string tag);
        logic [31:0] d;
        logic [43:0] rec;
        for (int b = 0; b < beats; b++) begin
            d = mkd(p, n, b);
            if (outq.size() == 0) begin
                check_val(tag, 64'hFFFF_FFFF_FFFF_FFFF, {20'd0, 3'(p), (b == beats - 1), d[7:0] ^ 8'h5A, d});
            end else begin
                rec = outq.pop_front();
                check_val(tag, {20'd0, rec}, {20'd0, 3'(p), (b == beats - 1), d[7:0] ^ 8'h5A, d});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        s_tvalid = 4'hF;
        m_tready = 1'b1;
        ctrl     = 32'h0001_0000;

        // Reset state, with traffic and drop mode present to exercise the hold-off.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",   64'(busy), 64'd0);
        check_val("rst_mvalid", 64'(m_tvalid), 64'd0);
        check_val("rst_sready", 64'(s_tready), 64'd0);
        check_val("rst_grant",  64'(grant_port), 64'd3);
        check_val("rst_cnts",   64'({pkt_count, drop_count}), 64'd0);
        @(posedge clk);
        #1;
        s_tvalid = '0;
        ctrl     = 32'h0000_000F;
        rst_n    = 1'b1;

        // Round robin: three single-beat packets per port.
        for (int n = 0; n < 3; n++)
            for (int p = 0; p < NP; p++) push_pkt(p, n, 1);
        run(30);
        check_val("rr_nbeats", 64'(outq.size()), 64'd12);
        for (int n = 0; n < 3; n++)
            for (int p = 0; p < NP; p++) expect_out(p, n, 1, "rr_order");
        for (int p = 0; p < NP; p++) check_val("rr_pktcnt", 64'(pcnt(p)), 64'd3);

        // Counter clear, then a 5-beat packet under toggling backpressure.
        ctrl = 32'h8000_000F;
        run(1);
        ctrl = 32'h0000_000F;
        check_val("clr_cnts", 64'(pkt_count), 64'd0);
        push_pkt(1, 0, 5);
        tr_mode = 1'b1;
        tog     = 1'b0;
        run(20);
        tr_mode = 1'b0;
        check_val("bp_nbeats", 64'(outq.size()), 64'd5);
        expect_out(1, 0, 5, "bp_beat");
        check_val("bp_pktcnt1", 64'(pcnt(1)), 64'd1);

        // Port 0 disabled with drop on, concurrent with port 2 forwarding.
        ctrl = 32'h0001_000E;
        push_pkt(0, 0, 2);
        push_pkt(2, 0, 4);
        run(2);
        check_val("drop_drained", 64'(srcq[0].size()), 64'd0);
        check_val("drop_cnt0",    64'(dcnt(0)), 64'd1);
        run(6);
        check_val("drop_nbeats", 64'(outq.size()), 64'd4);
        expect_out(2, 0, 4, "drop_fwd");
        check_val("drop_pktcnt2", 64'(pcnt(2)), 64'd1);
        check_val("drop_pktcnt0", 64'(pcnt(0)), 64'd0);
        check_val("drop_cnt0_hold", 64'(dcnt(0)), 64'd1);

        // Port 3 disabled mid-packet with drop off: finishes, next packet held.
        ctrl = 32'h0000_000F;
        push_pkt(3, 0, 6);
        push_pkt(3, 1, 1);
        run(3);
        ctrl = 32'h0000_0007;
        run(8);
        drive();
        #1;
        check_val("dis_held",   64'(srcq[3].size()), 64'd1);
        check_val("dis_sready", 64'(s_tready[3]), 64'd0);
        check_val("dis_mvalid", 64'(m_tvalid), 64'd0);
        check_val("dis_nbeats", 64'(outq.size()), 64'd6);
        expect_out(3, 0, 6, "dis_fwd");
        check_val("dis_pktcnt3", 64'(pcnt(3)), 64'd1);
        srcq[3].delete();
        ctrl = 32'h0000_000F;

        // Counter wrap and clear-over-increment priority.
        ctrl = 32'h8000_000F;
        run(1);
        ctrl = 32'h0000_000F;
        for (int n = 0; n < 15; n++) push_pkt(0, n, 1);
        run(34);
        check_val("wrap_max", 64'(pcnt(0)), 64'd15);
        push_pkt(0, 15, 1);
        run(3);
        check_val("wrap_zero", 64'(pcnt(0)), 64'd0);
        check_val("wrap_nbeats", 64'(outq.size()), 64'd16);
        outq.delete();
        push_pkt(0, 16, 1);
        run(1);
        ctrl = 32'h8000_000F;
        run(1);
        ctrl = 32'h0000_000F;
        check_val("clr_prio", 64'(pcnt(0)), 64'd0);
        check_val("clr_out",  64'(outq.size()), 64'd1);
        outq.delete();

        // Reset pulsed in the middle of a packet.
        push_pkt(1, 0, 1);
        push_pkt(2, 0, 5);
        run(5);
        check_val("mid_pre_cnt1", 64'(pcnt(1)), 64'd1);
        drive();
        #1;
        check_val("mid_pre_data", 64'(m_tvalid ? m_tdata : 32'd0), 64'(mkd(2, 0, 2)));
        rst_n = 1'b0;
        #1;
        check_val("mid_mvalid", 64'(m_tvalid), 64'd0);
        check_val("mid_busy",   64'(busy), 64'd0);
        check_val("mid_grant",  64'(grant_port), 64'd3);
        check_val("mid_cnts",   64'({pkt_count, drop_count}), 64'd0);
        for (int p = 0; p < NP; p++) srcq[p].delete();
        outq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_pkt(2, 1, 1);
        push_pkt(1, 1, 1);
        push_pkt(0, 1, 1);
        run(8);
        expect_out(0, 1, 1, "post_rst_order");
        expect_out(1, 1, 1, "post_rst_order");
        expect_out(2, 1, 1, "post_rst_order");
        check_val("post_rst_cnt2", 64'(pcnt(2)), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
